// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - display bus and capture result bundle for seg_scan_capture
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              i_seg;
    logic [NUM_DIGITS-1:0]   i_digit_sel;
    logic                    i_invert;
    logic                    i_clear;
    logic [4*NUM_DIGITS-1:0] o_digits;
    logic [NUM_DIGITS-1:0]   o_valid;
    logic [NUM_DIGITS-1:0]   o_blank;
    logic                    o_update;
    logic                    o_error;

    modport master (
        output i_seg, i_digit_sel, i_invert, i_clear,
        input  o_digits, o_valid, o_blank, o_update, o_error
    );

    modport slave (
        input  i_seg, i_digit_sel, i_invert, i_clear,
        output o_digits, o_valid, o_blank, o_update, o_error
    );
endinterface

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - settle-filtered readback of a multiplexed 7-segment bus
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    seg_scan_if.slave  bus
);
    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    inv_q, inv_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    update_q, update_d;
    logic                    error_q, error_d;
    logic [6:0]              seg_in;
    logic                    changed;
    logic [4:0]              dec;

    // Returns {hit, nibble}; exact gfedcba match only.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0111111: decode = 5'h10;
            7'b0000110: decode = 5'h11;
            7'b1011011: decode = 5'h12;
            7'b1001111: decode = 5'h13;
            7'b1100110: decode = 5'h14;
            7'b1101101: decode = 5'h15;
            7'b1111101: decode = 5'h16;
            7'b0000111: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1101111: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b1111100: decode = 5'h1B;
            7'b0111001: decode = 5'h1C;
            7'b1011110: decode = 5'h1D;
            7'b1111001: decode = 5'h1E;
            7'b1110001: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    assign seg_in  = bus.i_seg ^ {7{bus.i_invert}};
    assign changed = ({bus.i_invert, seg_in, bus.i_digit_sel} != {inv_q, seg_q, sel_q});
    assign dec     = decode(seg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seg_d    = seg_in;
        sel_d    = bus.i_digit_sel;
        inv_d    = bus.i_invert;
        digits_d = digits_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        error_d  = error_q;
        update_d = 1'b0;

        // Clear is applied first so a same-edge capture overrides it.
        if (bus.i_clear) begin
            valid_d = '0;
            blank_d = '0;
            error_d = 1'b0;
        end

        if (changed) begin
            cnt_d   = '0;
            state_d = (bus.i_digit_sel == '0) ? IDLE : SETTLE;
        end else begin
            case (state_q)
                IDLE: cnt_d = '0;
                SETTLE: begin
                    if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                        cnt_d    = '0;
                        state_d  = HELD;
                        update_d = 1'b1;
                        if (!$onehot(sel_q)) begin
                            error_d = 1'b1;
                        end else if (seg_q == 7'b0) begin
                            blank_d = blank_d | sel_q;
                            valid_d = valid_d & ~sel_q;
                        end else if (!dec[4]) begin
                            error_d = 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_DIGITS; k++) begin
                                if (sel_q[k]) begin
                                    digits_d[4*k +: 4] = dec[3:0];
                                    valid_d[k]         = 1'b1;
                                    blank_d[k]         = 1'b0;
                                end
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seg_q    <= '0;
            sel_q    <= '0;
            inv_q    <= 1'b0;
            digits_q <= '0;
            valid_q  <= '0;
            blank_q  <= '0;
            update_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
            inv_q    <= inv_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            update_q <= update_d;
            error_q  <= error_d;
        end
    end

    assign bus.o_digits = digits_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_blank  = blank_q;
    assign bus.o_update = update_q;
    assign bus.o_error  = error_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - scoreboard bench for seg_scan_capture
module tb_seg_scan_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  v;
        logic [3:0]  b;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic apply(input logic [6:0] seg, input logic [3:0] sel, input logic inv);
        bus.i_seg       = seg;
        bus.i_digit_sel = sel;
        bus.i_invert    = inv;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_cap(input logic [15:0] d, input logic [3:0] v, input logic [3:0] b, input logic e);
        exp_t x;
        x.d = d; x.v = v; x.b = b; x.e = e;
        exp_q.push_back(x);
    endtask

    // Walks a fresh dwell edge by edge; the update must appear on the 5th edge only.
    task automatic watch_update(input string name);
        for (int i = 1; i <= 5; i++) begin
            hold(1);
            check(name, 32'(bus.o_update), 32'(i == 5));
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_digits"}, 32'(bus.o_digits), 32'h0);
        check({name, "_valid"},  32'(bus.o_valid),  32'h0);
        check({name, "_blank"},  32'(bus.o_blank),  32'h0);
        check({name, "_update"}, 32'(bus.o_update), 32'h0);
        check({name, "_error"},  32'(bus.o_error),  32'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_update) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got digits %0h valid %0h", bus.o_digits, bus.o_valid);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("cap_digits", 32'(bus.o_digits), 32'(x.d));
                check("cap_valid",  32'(bus.o_valid),  32'(x.v));
                check("cap_blank",  32'(bus.o_blank),  32'(x.b));
                check("cap_error",  32'(bus.o_error),  32'(x.e));
            end
        end
    end

    initial begin
        bus.i_clear = 1'b0;
        apply(7'h00, 4'h0, 1'b0);
        hold(3);
        check_zero("reset");
        rst_n = 1'b1;
        hold(2);

        // T1: decode of '2' on digit 0
        apply(7'b1011011, 4'b0001, 1'b0);
        expect_cap(16'h0002, 4'b0001, 4'b0000, 1'b0);
        watch_update("t1_update_edge");
        hold(1);
        check("t1_no_repeat", 32'(bus.o_update), 32'h0);
        hold(3);
        apply(7'h00, 4'h0, 1'b0);
        hold(2);

        // T2: active-low segments, 'E' on digit 2
        apply(7'b0000110, 4'b0100, 1'b1);
        expect_cap(16'h0E02, 4'b0101, 4'b0000, 1'b0);
        hold(7);
        apply(7'h00, 4'h0, 1'b0);
        hold(2);

        // T3: 3-edge glitch then '7' on digit 1
        apply(7'b1001111, 4'b0010, 1'b0);
        hold(3);
        apply(7'b0000111, 4'b0010, 1'b0);
        expect_cap(16'h0E72, 4'b0111, 4'b0000, 1'b0);
        hold(8);
        apply(7'h00, 4'h0, 1'b0);
        hold(2);

        // T4: illegal pattern then clear
        apply(7'b1000000, 4'b1000, 1'b0);
        expect_cap(16'h0E72, 4'b0111, 4'b0000, 1'b1);
        hold(7);
        bus.i_clear = 1'b1;
        hold(1);
        bus.i_clear = 1'b0;
        check("t4_clr_error",  32'(bus.o_error),  32'h0);
        check("t4_clr_valid",  32'(bus.o_valid),  32'h0);
        check("t4_keep_digit", 32'(bus.o_digits), 32'h0E72);
        apply(7'h00, 4'h0, 1'b0);
        hold(2);

        // T5: non-one-hot select, then a long blanking interval
        apply(7'b0000110, 4'b0011, 1'b0);
        expect_cap(16'h0E72, 4'b0000, 4'b0000, 1'b1);
        hold(7);
        bus.i_clear = 1'b1;
        hold(1);
        bus.i_clear = 1'b0;
        check("t5_clr_error", 32'(bus.o_error), 32'h0);
        apply(7'h00, 4'h0, 1'b0);
        hold(20);
        check("t5_idle_error",  32'(bus.o_error),  32'h0);
        check("t5_idle_digits", 32'(bus.o_digits), 32'h0E72);

        // T6: blank digit 1, then reset in the middle of a dwell
        apply(7'b0000000, 4'b0010, 1'b0);
        expect_cap(16'h0E72, 4'b0000, 4'b0010, 1'b0);
        hold(7);
        check("t6_blank", 32'(bus.o_blank), 32'h2);
        apply(7'b1101101, 4'b0001, 1'b0);
        hold(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async_reset");
        hold(2);
        rst_n = 1'b1;
        expect_cap(16'h0005, 4'b0001, 4'b0000, 1'b0);
        watch_update("t6_post_reset_edge");
        hold(4);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Monitors a multiplexed 7-segment display bus: segment lines plus one-hot digit select.
- Waits for each selected digit's pattern to settle, then decodes it back to its 4-bit hex value and holds one register per digit.
- Serves as display readback for self-check and scoreboard mirroring, and as the decode end of the binary-to-7-segment encoding used for the score displays.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits, one select line each
STABLE_CYCLES, 4, consecutive clock edges a segment/select pair must stay unchanged before capture (minimum 1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
i_seg  in  7  segment lines; bit0=a … bit6=g
i_digit_sel  in  NUM_DIGITS  digit select, active-high, expected one-hot or all-zero
i_invert  in  1  1 = segments active-low; i_seg is inverted before any other use
i_clear  in  1  synchronous clear of o_valid, o_blank and o_error
o_digits  out  4*NUM_DIGITS  captured nibble; digit k at [4k+3:4k]
o_valid  out  NUM_DIGITS  digit k holds a decoded value
o_blank  out  NUM_DIGITS  last capture of digit k was all segments off
o_update  out  1  one-cycle pulse on any capture edge (decode, blank or error)
o_error  out  1  sticky; set by an illegal pattern or by a stable non-one-hot select

Behaviour:
- Reset (asynchronous, immediate): every output 0; stability counter 0; FSM in IDLE.
- Sampling
  - Inputs are registered once. The compared pair is {i_seg after inversion, i_digit_sel}.
  - Let E0 be the first edge that samples a new pair.
  - If the pair stays unchanged through edge E0+STABLE_CYCLES, the capture takes effect at that edge. Outputs and o_update are registered.
  - Any change before that restarts the count from the changed pair. Exactly one capture happens per dwell.
- FSM
  - IDLE: select all-zero (blanking interval). Counter held at 0; no capture, no error. Non-zero select -> SETTLE.
  - SETTLE: counting. Pair change -> restart SETTLE, or IDLE if select becomes 0. Count complete -> capture, then HELD.
  - HELD: no further captures. Pair change -> SETTLE, or IDLE if select becomes 0.
- Capture, one-hot select on digit k; decode table is exact 7-bit gfedcba match:
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111
  - 4:1100110, 5:1101101, 6:1111101, 7:0000111
  - 8:1111111, 9:1101111, A:1110111, b:1111100
  - C:0111001, d:1011110, E:1111001, F:1110001
  - Match: nibble k <= value, o_valid[k]=1, o_blank[k]=0.
  - 0000000: o_blank[k]=1, o_valid[k]=0, nibble k unchanged.
  - Any other pattern: o_error=1; digit k registers unchanged.
  - o_update pulses in all three cases.
- Capture with stable non-zero, non-one-hot select: o_error=1, no digit updated, o_update pulses.
- i_clear
  - Clears o_valid, o_blank and o_error at the next edge; o_digits are kept.
  - Same edge as a capture: the capture's set of valid/blank/error wins over the clear.
- o_update is never asserted on two consecutive edges for the same dwell.
- i_invert change counts as a pair change.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
1. Decode: sel=0001, seg=1011011, invert=0, held 5 edges -> o_digits[3:0]=2, o_valid=0001, one o_update pulse on the 5th edge only.
2. Inverted segments: invert=1, seg=0000110 (~1111001), sel=0100, held 5 edges -> o_digits[11:8]=E, o_valid[2]=1.
3. Glitch rejection: pair held 3 edges, then changed -> no update; new pair held 5 edges -> captured once.
4. Illegal pattern and clear: seg=1000000, sel=1000 -> o_error=1, digits unchanged. i_clear pulse -> o_error=0, o_valid=0000, o_digits retained.
5. Select faults: sel=0011 stable 5 edges -> o_error=1, no digit change. sel=0000 for 20 edges -> no update, no error.
6. Blank and reset: seg=0000000 on sel=0010 -> o_blank=0010, o_valid[1]=0. Then i_rst_n low 2 edges into a new dwell -> all outputs 0 at once; after release a full 5-edge dwell is needed before the next capture.
